// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a flop-based register file. It supports programmable
// wait states, PSLVERR for out-of-range addresses and a sticky protocol-violation flag.
module apb_slave_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int WAIT_W     = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [WAIT_W-1:0]     wait_cycles,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  proto_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  // The SETUP phase is the IDLE cycle that sees PSEL without PENABLE. Its closing
  // edge latches the request, so a registered PREADY can still land in the first
  // access cycle.
  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  proto_err_q, proto_err_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];
  logic                  mem_we;
  logic                  mismatch;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  assign mismatch = (PADDR != addr_q) || (PWRITE != write_q) || (PWDATA != wdata_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    pready_d    = 1'b0;
    prdata_d    = '0;
    pslverr_d   = 1'b0;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (PENABLE) begin
          proto_err_d = 1'b1;
        end else if (PSEL) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = wait_cycles;
          state_d = S_ACCESS;
          if (wait_cycles == '0) begin
            pready_d  = 1'b1;
            pslverr_d = !in_range(PADDR);
            prdata_d  = (!PWRITE && in_range(PADDR)) ? mem_q[PADDR[IDX_W-1:0]] : '0;
          end
        end
      end

      S_ACCESS: begin
        if (pready_q) begin
          // Completion cycle: commit the write on its closing edge
          state_d = S_IDLE;
          mem_we  = write_q && in_range(addr_q);
          if (PSEL && PENABLE && mismatch) proto_err_d = 1'b1;
        end else if (!PSEL || !PENABLE) begin
          proto_err_d = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end else begin
          if (mismatch) proto_err_d = 1'b1;
          if (cnt_q <= WAIT_W'(1)) begin
            cnt_d     = '0;
            pready_d  = 1'b1;
            pslverr_d = !in_range(addr_q);
            prdata_d  = (!write_q && in_range(addr_q)) ? mem_q[addr_q[IDX_W-1:0]] : '0;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (mem_we) mem_d[addr_q[IDX_W-1:0]] = wdata_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      pready_q    <= pready_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      proto_err_q <= proto_err_d;
      mem_q       <= mem_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized and directed bench for apb_slave_mem. A transfer-level model predicts
// the outputs for every cycle, and a negedge process compares them with the DUT.
`timescale 1ns/1ps
module tb_apb_slave_mem;
  localparam int AW = 8, DW = 8, DEPTH = 64, WW = 4;

  logic          PCLK = 1'b0, PRESETn = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [WW-1:0] wait_cycles = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR, proto_err;

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_W(WW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .wait_cycles(wait_cycles),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .proto_err(proto_err)
  );

  always #5 PCLK = ~PCLK;

  // Reference state: memory contents and the sticky violation flag
  logic [DW-1:0] mem_m [DEPTH];
  logic          proto_m = 1'b0;
  logic          exp_pready = 1'b0, exp_pslverr = 1'b0, exp_proto = 1'b0;
  logic [DW-1:0] exp_prdata = '0;

  int            n_vec = 0, n_err = 0, cyc_cnt = 0, t_setup = 0, t_ready = 0;
  logic [DW-1:0] last_prdata = '0;
  logic          last_pslverr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge PCLK) cyc_cnt <= cyc_cnt + 1;

  always @(negedge PCLK) begin
    check("pready", {31'd0, PREADY}, {31'd0, exp_pready});
    check("prdata", {24'd0, PRDATA}, {24'd0, exp_prdata});
    check("pslverr", {31'd0, PSLVERR}, {31'd0, exp_pslverr});
    check("proto_err", {31'd0, proto_err}, {31'd0, exp_proto});
    if (PREADY === 1'b1) begin
      last_prdata  <= PRDATA;
      last_pslverr <= PSLVERR;
      t_ready      <= cyc_cnt;
    end
  end

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    proto_m = 1'b0;
  endtask

  task automatic exp_quiet();
    exp_pready  = 1'b0;
    exp_prdata  = '0;
    exp_pslverr = 1'b0;
    exp_proto   = proto_m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      PSEL = 1'b0; PENABLE = 1'b0;
      exp_quiet();
      cyc();
    end
  endtask

  task automatic idle_penable_violation();
    PSEL = 1'b0; PENABLE = 1'b1;
    exp_quiet();
    proto_m = 1'b1;
    cyc();
    PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESETn = 1'b0;
    clear_model();
    exp_quiet();
    cyc();
    cyc();
    PRESETn = 1'b1;
    exp_quiet();
    cyc();
  endtask

  // abort_at/bad_at/rst_at: access cycle (1-based) in which to drop PSEL, corrupt
  // PADDR or pulse reset; 0 disables the event.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int w, input int abort_at, input int bad_at, input int rst_at);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    wait_cycles = WW'(w);
    t_setup = cyc_cnt;
    exp_quiet();
    cyc();
    for (int k = 1; k <= w + 1; k++) begin
      PENABLE = 1'b1; PADDR = a; PWDATA = d; wait_cycles = '0;
      exp_quiet();
      if (k == abort_at) begin
        PSEL = 1'b0; PENABLE = 1'b0;
        proto_m = 1'b1;
        cyc();
        return;
      end
      if (k == bad_at) begin
        PADDR = a ^ 8'h01;
        proto_m = 1'b1;
      end
      if (k == w + 1) begin
        exp_pready  = 1'b1;
        exp_pslverr = (a >= DEPTH);
        exp_prdata  = (!wr && a < DEPTH) ? mem_m[a] : '0;
      end
      if (k == rst_at) begin
        #6;
        check("pre_rst_prdata", {24'd0, PRDATA}, {24'd0, exp_prdata});
        PRESETn = 1'b0;
        #1;
        check("async_rst_pready", {31'd0, PREADY}, 32'd0);
        check("async_rst_prdata", {24'd0, PRDATA}, 32'd0);
        check("async_rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("async_rst_proto", {31'd0, proto_err}, 32'd0);
        clear_model();
        PSEL = 1'b0; PENABLE = 1'b0;
        exp_quiet();
        cyc();
        return;
      end
      cyc();
    end
    if (wr && a < DEPTH) mem_m[a] = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            w, ab, bd;

    clear_model();
    #1 PRESETn = 1'b0;
    repeat (3) cyc();
    PRESETn = 1'b1;
    idle(2);
    check("rst_proto", {31'd0, proto_err}, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd0);

    // Zero-wait write then read
    xfer(1'b1, 8'd3, 8'hA5, 0, 0, 0, 0);
    xfer(1'b0, 8'd3, 8'h00, 0, 0, 0, 0);
    check("rd3_data", {24'd0, last_prdata}, 32'hA5);
    check("rd3_lat", t_ready - t_setup, 32'd1);
    check("rd3_err", {31'd0, last_pslverr}, 32'd0);

    // Three wait states; wait_cycles forced to 0 during access
    idle(1);
    xfer(1'b0, 8'd3, 8'h00, 3, 0, 0, 0);
    check("rd3w_data", {24'd0, last_prdata}, 32'hA5);
    check("rd3w_lat", t_ready - t_setup, 32'd4);

    // Out-of-range accesses, no aliasing onto addr 0
    xfer(1'b1, 8'd64, 8'h5A, 0, 0, 0, 0);
    check("wr64_err", {31'd0, last_pslverr}, 32'd1);
    xfer(1'b0, 8'd64, 8'h00, 0, 0, 0, 0);
    check("rd64_err", {31'd0, last_pslverr}, 32'd1);
    check("rd64_data", {24'd0, last_prdata}, 32'h00);
    xfer(1'b0, 8'd0, 8'h00, 0, 0, 0, 0);
    check("rd0_data", {24'd0, last_prdata}, 32'h00);
    check("rd0_err", {31'd0, last_pslverr}, 32'd0);

    // Back-to-back with PSEL held
    xfer(1'b1, 8'd10, 8'h11, 0, 0, 0, 0);
    xfer(1'b1, 8'd11, 8'h22, 0, 0, 0, 0);
    xfer(1'b0, 8'd10, 8'h00, 0, 0, 0, 0);
    check("b2b_data", {24'd0, last_prdata}, 32'h11);
    check("b2b_lat", t_ready - t_setup, 32'd1);

    // Aborted write: PSEL dropped in 2nd access cycle
    idle(1);
    xfer(1'b1, 8'd7, 8'hFF, 5, 2, 0, 0);
    idle(2);
    check("abort_proto", {31'd0, proto_err}, 32'd1);
    xfer(1'b0, 8'd7, 8'h00, 0, 0, 0, 0);
    check("abort_rd7", {24'd0, last_prdata}, 32'h00);
    idle(3);
    check("proto_sticky", {31'd0, proto_err}, 32'd1);

    // Asynchronous reset inside the PREADY cycle of a 4-wait read
    xfer(1'b1, 8'd2, 8'h33, 0, 0, 0, 0);
    xfer(1'b0, 8'd2, 8'h00, 4, 0, 0, 5);
    PRESETn = 1'b1;
    idle(1);
    xfer(1'b0, 8'd2, 8'h00, 0, 0, 0, 0);
    check("post_rst_rd2", {24'd0, last_prdata}, 32'h00);
    check("post_rst_proto", {31'd0, proto_err}, 32'd0);

    // PENABLE without a SETUP
    idle_penable_violation();
    idle(1);
    check("idle_pen_proto", {31'd0, proto_err}, 32'd1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(64, 255)) : AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      w  = $urandom_range(0, 3);
      ab = (w >= 1 && $urandom_range(0, 11) == 0) ? $urandom_range(1, w) : 0;
      bd = ($urandom_range(0, 14) == 0) ? $urandom_range(1, w + 1) : 0;
      xfer(wr, a, d, w, ab, bd, 0);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer (slave) with an internal register-file memory.
- Sits on the far side of the team's APB master wrapper: consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Provides a run-time programmable wait-state count, out-of-range error reporting and a sticky protocol-violation flag.
- Serves as the default DUT-side slave for APB VIP regressions.

Parameters:
- ADDR_WIDTH, 8, width of PADDR.
- DATA_WIDTH, 8, width of PWDATA/PRDATA and of each memory word.
- MEM_DEPTH, 64, number of words; valid addresses are 0..MEM_DEPTH-1.
- WAIT_W, 4, width of the wait_cycles input.

Ports:
- PCLK  input  1  clock; all logic is on the rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  word address.
- PWDATA  input  DATA_WIDTH  write data.
- wait_cycles  input  WAIT_W  wait states to insert; sampled in SETUP.
- PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  error response; valid only while PREADY=1.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - State goes to IDLE.
  - PRDATA=0, PREADY=0, PSLVERR=0, proto_err=0.
  - All memory words are cleared to 0 and the wait counter is cleared.
  - Reset asserted mid-transfer aborts the transfer with no memory write.
- FSM states and transitions:
  - IDLE: PSEL=1 and PENABLE=0 -> SETUP.
  - SETUP (one cycle): latch PADDR, PWRITE, PWDATA and wait_cycles into cnt -> ACCESS.
  - ACCESS, cnt>0: PREADY=0, cnt decrements each cycle.
  - ACCESS, cnt==0: PREADY=1 for exactly one cycle, then -> SETUP if PSEL=1 and PENABLE=0, else -> IDLE.
- Latency: PREADY rises in ACCESS cycle wait_cycles+1. With wait_cycles=0, PREADY=1 in the first cycle PENABLE=1, i.e. a 2-cycle APB transfer.
- PREADY, PRDATA and PSLVERR are registered. When PREADY=0, PRDATA and PSLVERR are held at 0.
- Read: in the PREADY cycle, PRDATA = mem[latched addr].
- Write: mem[latched addr] <= latched PWDATA at the rising edge that ends the PREADY=1 cycle. PRDATA=0 for writes.
- Address error: latched addr >= MEM_DEPTH gives PSLVERR=1 in the PREADY cycle. A write is discarded and a read returns PRDATA=0. Wait states still apply.
- Back-to-back transfers: after the PREADY cycle, PSEL=1 with PENABLE=0 starts a new SETUP with no IDLE gap.
- Protocol violations (set proto_err=1, which stays set until reset):
  - PENABLE=1 while in IDLE. State stays IDLE and no response is given.
  - In ACCESS, PADDR, PWRITE or PWDATA differs from the latched value.
  - PSEL=0 during ACCESS before PREADY. The transfer is aborted (no write, PREADY stays 0) and the FSM -> IDLE.
  - PENABLE=0 with PSEL=1 during ACCESS before PREADY. Treated the same as the PSEL=0 abort.
- wait_cycles changes after SETUP have no effect on the current transfer.

Test Plan:
- Reset, then write 0xA5 to addr 3 with wait_cycles=0, then read addr 3 -> write completes with PREADY=1 in the first ACCESS cycle. The read returns PRDATA=0xA5, PSLVERR=0, 2 cycles per transfer.
- wait_cycles=3, read addr 3 -> PREADY=0 for 3 ACCESS cycles, then 1 in the 4th with PRDATA=0xA5. wait_cycles changed to 0 mid-access does not shorten the transfer.
- Write 0x5A to addr 64 (MEM_DEPTH=64), then read addr 64 -> PSLVERR=1 in both PREADY cycles and read PRDATA=0. A read of addr 0 returns 0x00, proving no wrap-around or alias.
- Back-to-back: write addr 10=0x11, write addr 11=0x22, read addr 10 with PSEL held high throughout -> each transfer takes 2 cycles, read returns 0x11, no IDLE gap.
- wait_cycles=5, PSEL dropped in the 2nd ACCESS cycle of a write to addr 7 with data 0xFF -> proto_err=1, FSM in IDLE, a subsequent read of addr 7 returns 0x00. proto_err stays 1 until PRESETn is pulsed.
- PRESETn asserted mid-ACCESS (wait_cycles=4) after mem[2]=0x33 -> all outputs are 0 immediately (asynchronous). After release, a read of addr 2 returns 0x00 and proto_err=0.
